// File: rtl/popcnt_pkg.sv
// Shared constants and helpers for the pipelined popcount compressor.
// sat_add works on up to 64-bit operands; bit 64 of the result flags a clipped sum.
package popcnt_pkg;

    localparam int GRP_W     = 4;
    localparam int GRP_CNT_W = 3;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic logic [64:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int w);
        logic [64:0] sum;
        logic [63:0] maxVal;
        sum    = {1'b0, a} + {1'b0, b};
        maxVal = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        if (sum > {1'b0, maxVal}) begin
            return {1'b1, maxVal};
        end
        return sum;
    endfunction

endpackage

// File: rtl/popcnt_compress_pipe_group4.sv
// Combinational 4-bit population counter: one full adder on bits 0..2,
// then two half adders fold in bit 3 and merge the carries.
module popcnt_group4
    import popcnt_pkg::*;
(
    input  logic [GRP_W-1:0]     bits_i,
    output logic [GRP_CNT_W-1:0] count_o
);

    logic faSum;
    logic faCarry;
    logic haCarry;

    assign faSum   = bits_i[0] ^ bits_i[1] ^ bits_i[2];
    assign faCarry = (bits_i[0] & bits_i[1]) | (bits_i[2] & (bits_i[0] ^ bits_i[1]));
    assign haCarry = faSum & bits_i[3];
    assign count_o = {faCarry & haCarry, faCarry ^ haCarry, faSum ^ bits_i[3]};

endmodule

// File: rtl/popcnt_compress_pipe.sv
// Two-stage popcount pipeline: S1 registers per-group counts, S2 sums them and
// updates the saturating per-packet accumulator. Valid/ready with bubble collapse.
module popcnt_compress_pipe
    import popcnt_pkg::*;
#(
    parameter  int IN_W  = 16,
    parameter  int ACC_W = 16,
    localparam int CNT_W = cnt_w(IN_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    input  logic             acc_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_last,
    output logic             out_overflow
);

    localparam int NGRP = IN_W / GRP_W;

    logic [NGRP-1:0][GRP_CNT_W-1:0] grpCnt;
    logic [NGRP-1:0][GRP_CNT_W-1:0] s1Grp_q;
    logic                           s1Valid_q;
    logic                           s1Last_q;
    logic                           s1AccEn_q;

    logic             outValid_q;
    logic [CNT_W-1:0] outCount_q;
    logic [ACC_W-1:0] outAcc_q;
    logic             outLast_q;
    logic             outOvf_q;
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;

    logic             s2Adv;
    logic             s1Adv;
    logic [CNT_W-1:0] grpSum_d;
    logic [ACC_W-1:0] accNext_d;
    logic             ovfNext_d;
    logic [64:0]      satRes;
    logic             unusedSatBits;

    for (genvar g = 0; g < NGRP; g++) begin : gGrp
        popcnt_group4 uGrp (
            .bits_i  (in_data[g*GRP_W +: GRP_W]),
            .count_o (grpCnt[g])
        );
    end

    assign s2Adv    = !outValid_q || out_ready;
    assign s1Adv    = !s1Valid_q || s2Adv;
    assign in_ready = s1Adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid_q <= 1'b0;
            s1Grp_q   <= '0;
            s1Last_q  <= 1'b0;
            s1AccEn_q <= 1'b0;
        end else if (s1Adv) begin
            s1Valid_q <= in_valid;
            if (in_valid) begin
                s1Grp_q   <= grpCnt;
                s1Last_q  <= in_last;
                s1AccEn_q <= acc_en;
            end
        end
    end

    always_comb begin
        grpSum_d = '0;
        for (int g = 0; g < NGRP; g++) begin
            grpSum_d = grpSum_d + CNT_W'(s1Grp_q[g]);
        end
    end

    assign satRes        = sat_add(64'(acc_q), 64'(grpSum_d), ACC_W);
    assign unusedSatBits = ^satRes[63:ACC_W];

    always_comb begin
        accNext_d = ACC_W'(grpSum_d);
        ovfNext_d = 1'b0;
        if (s1AccEn_q) begin
            accNext_d = satRes[ACC_W-1:0];
            ovfNext_d = ovf_q | satRes[64];
        end
    end

    // A last beat can only be followed by a capture once it has left S2, so
    // clearing the running state at its own capture is observably the same.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid_q <= 1'b0;
            outCount_q <= '0;
            outAcc_q   <= '0;
            outLast_q  <= 1'b0;
            outOvf_q   <= 1'b0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
        end else if (s2Adv) begin
            outValid_q <= s1Valid_q;
            if (s1Valid_q) begin
                outCount_q <= grpSum_d;
                outAcc_q   <= accNext_d;
                outLast_q  <= s1Last_q;
                outOvf_q   <= ovfNext_d;
                acc_q      <= s1Last_q ? '0 : accNext_d;
                ovf_q      <= s1Last_q ? 1'b0 : ovfNext_d;
            end
        end
    end

    assign out_valid    = outValid_q;
    assign out_count    = outCount_q;
    assign out_acc      = outAcc_q;
    assign out_last     = outLast_q;
    assign out_overflow = outOvf_q;

endmodule

// File: tb/tb_popcnt_compress_pipe.sv
// Self-checking bench: directed scenarios on a 16-bit instance and a 5-bit
// accumulator instance, plus a randomized sweep over 4/8/32-bit instances.
module tb_popcnt_compress_pipe;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        en;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    logic        mInValid, mInReady, mInLast, mAccEn, mOutValid, mOutReady, mOutLast, mOutOvf;
    logic [15:0] mInData, mOutAcc;
    logic [4:0]  mOutCount;

    logic        sInValid, sInReady, sInLast, sAccEn, sOutValid, sOutReady, sOutLast, sOutOvf;
    logic [15:0] sInData;
    logic [4:0]  sOutCount, sOutAcc;

    logic        wInValid, wInLast, wAccEn, wOutReady;
    logic [31:0] wInData;
    logic        w4InReady, w4OutValid, w4OutLast, w4OutOvf;
    logic [2:0]  w4OutCount;
    logic [15:0] w4OutAcc;
    logic        w8InReady, w8OutValid, w8OutLast, w8OutOvf;
    logic [3:0]  w8OutCount;
    logic [15:0] w8OutAcc;
    logic        w32InReady, w32OutValid, w32OutLast, w32OutOvf;
    logic [5:0]  w32OutCount;
    logic [15:0] w32OutAcc;

    popcnt_compress_pipe #(.IN_W(16), .ACC_W(16)) dutMain (
        .clk(clk), .rst(rst), .in_valid(mInValid), .in_ready(mInReady), .in_data(mInData),
        .in_last(mInLast), .acc_en(mAccEn), .out_valid(mOutValid), .out_ready(mOutReady),
        .out_count(mOutCount), .out_acc(mOutAcc), .out_last(mOutLast), .out_overflow(mOutOvf));

    popcnt_compress_pipe #(.IN_W(16), .ACC_W(5)) dutSat (
        .clk(clk), .rst(rst), .in_valid(sInValid), .in_ready(sInReady), .in_data(sInData),
        .in_last(sInLast), .acc_en(sAccEn), .out_valid(sOutValid), .out_ready(sOutReady),
        .out_count(sOutCount), .out_acc(sOutAcc), .out_last(sOutLast), .out_overflow(sOutOvf));

    popcnt_compress_pipe #(.IN_W(4), .ACC_W(16)) dut4 (
        .clk(clk), .rst(rst), .in_valid(wInValid), .in_ready(w4InReady), .in_data(wInData[3:0]),
        .in_last(wInLast), .acc_en(wAccEn), .out_valid(w4OutValid), .out_ready(wOutReady),
        .out_count(w4OutCount), .out_acc(w4OutAcc), .out_last(w4OutLast), .out_overflow(w4OutOvf));

    popcnt_compress_pipe #(.IN_W(8), .ACC_W(16)) dut8 (
        .clk(clk), .rst(rst), .in_valid(wInValid), .in_ready(w8InReady), .in_data(wInData[7:0]),
        .in_last(wInLast), .acc_en(wAccEn), .out_valid(w8OutValid), .out_ready(wOutReady),
        .out_count(w8OutCount), .out_acc(w8OutAcc), .out_last(w8OutLast), .out_overflow(w8OutOvf));

    popcnt_compress_pipe #(.IN_W(32), .ACC_W(16)) dut32 (
        .clk(clk), .rst(rst), .in_valid(wInValid), .in_ready(w32InReady), .in_data(wInData),
        .in_last(wInLast), .acc_en(wAccEn), .out_valid(w32OutValid), .out_ready(wOutReady),
        .out_count(w32OutCount), .out_acc(w32OutAcc), .out_last(w32OutLast), .out_overflow(w32OutOvf));

    // Reference: popcount of the masked vector, then a running packet sum that
    // clips at the accumulator maximum and forgets everything after a last beat.
    function automatic void refBeat(input logic [31:0] data, input int width, input int accW,
                                    input logic en, input logic last,
                                    inout longint acc, inout bit ovf,
                                    output int cnt, output longint accOut, output bit ovfOut);
        logic [31:0] mask;
        longint      maxVal;
        longint      sum;
        mask   = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        maxVal = (longint'(1) << accW) - 1;
        cnt    = $countones(data & mask);
        if (en) begin
            sum = acc + longint'(cnt);
            ovf = ovf | (sum > maxVal);
            acc = (sum > maxVal) ? maxVal : sum;
        end else begin
            acc = longint'(cnt);
            ovf = 1'b0;
        end
        accOut = acc;
        ovfOut = ovf;
        if (last) begin
            acc = 0;
            ovf = 1'b0;
        end
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (mOutValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", mOutValid); end
        total++; if (mInReady !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", mInReady); end
        total++; if (mOutCount !== 5'd0) begin bad++; $display("[TB] FAIL reset_out_count got=%0d want=0", mOutCount); end
        total++; if (mOutAcc !== 16'd0) begin bad++; $display("[TB] FAIL reset_out_acc got=%0d want=0", mOutAcc); end
        total++; if ({mOutLast, mOutOvf} !== 2'b00) begin bad++; $display("[TB] FAIL reset_last_ovf got=%b want=00", {mOutLast, mOutOvf}); end
        total++; if ({w32InReady, w32OutValid} !== 2'b10) begin bad++; $display("[TB] FAIL reset_w32 got=%b want=10", {w32InReady, w32OutValid}); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single_beat();
        @(posedge clk); #1;
        mOutReady = 1'b1; mInValid = 1'b1; mInData = 16'hFFFF; mAccEn = 1'b0; mInLast = 1'b1;
        @(posedge clk); #1;
        mInValid = 1'b0;
        @(negedge clk);
        total++; if (mOutValid !== 1'b0) begin bad++; $display("[TB] FAIL single_early_valid got=%b want=0", mOutValid); end
        @(negedge clk);
        total++; if (mOutValid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid got=%b want=1", mOutValid); end
        total++; if (mOutCount !== 5'd16) begin bad++; $display("[TB] FAIL single_count got=%0d want=16", mOutCount); end
        total++; if (mOutAcc !== 16'd16) begin bad++; $display("[TB] FAIL single_acc got=%0d want=16", mOutAcc); end
        total++; if ({mOutLast, mOutOvf} !== 2'b10) begin bad++; $display("[TB] FAIL single_last_ovf got=%b want=10", {mOutLast, mOutOvf}); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] beats [5];
        logic        lasts [5];
        int          eCnt  [5];
        longint      eAcc  [5];
        bit          eOvf  [5];
        longint      acc = 0;
        bit          ovf = 1'b0;
        int          k = 0;
        int          firstCyc = -1;
        int          lastCyc = -1;
        beats = '{16'h0000, 16'h000F, 16'hF0F0, 16'h8001, 16'h0003};
        lasts = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) refBeat({16'h0, beats[i]}, 16, 16, 1'b1, lasts[i], acc, ovf, eCnt[i], eAcc[i], eOvf[i]);
        mOutReady = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(posedge clk); #1;
            if (cyc < 5) begin
                mInValid = 1'b1; mInData = beats[cyc]; mInLast = lasts[cyc]; mAccEn = 1'b1;
            end else begin
                mInValid = 1'b0;
            end
            @(negedge clk);
            if (mOutValid && mOutReady) begin
                if (k < 5) begin
                    total++; if (mOutCount !== 5'(eCnt[k])) begin bad++; $display("[TB] FAIL b2b_count[%0d] got=%0d want=%0d", k, mOutCount, eCnt[k]); end
                    total++; if (mOutAcc !== 16'(eAcc[k])) begin bad++; $display("[TB] FAIL b2b_acc[%0d] got=%0d want=%0d", k, mOutAcc, eAcc[k]); end
                    total++; if (mOutLast !== lasts[k]) begin bad++; $display("[TB] FAIL b2b_last[%0d] got=%b want=%b", k, mOutLast, lasts[k]); end
                end
                if (firstCyc < 0) firstCyc = cyc;
                lastCyc = cyc;
                k++;
            end
        end
        total++; if (k != 5) begin bad++; $display("[TB] FAIL b2b_beats got=%0d want=5", k); end
        total++; if (lastCyc - firstCyc != 4) begin bad++; $display("[TB] FAIL b2b_spacing got=%0d want=4", lastCyc - firstCyc); end
    endtask

    task automatic test_backpressure();
        logic [15:0] beats [6];
        int          eCnt  [6];
        longint      eAcc  [6];
        bit          eOvf  [6];
        longint      acc = 0;
        bit          ovf = 1'b0;
        int          idx = 0;
        int          k = 0;
        int          nAcc = 0;
        bit          took;
        bit          stable = 1'b1;
        logic [22:0] snap = '0;
        for (int i = 0; i < 6; i++) begin
            beats[i] = 16'($urandom());
            refBeat({16'h0, beats[i]}, 16, 16, 1'b1, i == 5, acc, ovf, eCnt[i], eAcc[i], eOvf[i]);
        end
        @(posedge clk); #1;
        mOutReady = 1'b0; mInValid = 1'b1; mInData = beats[0]; mInLast = 1'b0; mAccEn = 1'b1;
        fork
            begin
                for (int c = 0; c < 80 && idx < 6; c++) begin
                    @(negedge clk);
                    took = mInValid && mInReady;
                    @(posedge clk); #1;
                    if (took) begin
                        idx++;
                        if (idx < 6) begin
                            mInData = beats[idx]; mInLast = (idx == 5);
                        end else begin
                            mInValid = 1'b0;
                        end
                    end
                end
                total++; if (idx != 6) begin bad++; $display("[TB] FAIL bp_drive got=%0d want=6", idx); end
            end
            begin
                for (int c = 0; c < 6; c++) begin
                    @(negedge clk);
                    if (mInValid && mInReady) nAcc++;
                    if (c == 2) snap = {mOutValid, mOutCount, mOutAcc, mOutLast};
                    if (c > 2 && {mOutValid, mOutCount, mOutAcc, mOutLast} !== snap) stable = 1'b0;
                end
                total++; if (nAcc != 2) begin bad++; $display("[TB] FAIL bp_accepted got=%0d want=2", nAcc); end
                total++; if (mInReady !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready got=%b want=0", mInReady); end
                total++; if (!stable) begin bad++; $display("[TB] FAIL bp_stable got=changed want=held"); end
                total++; if (snap !== {1'b1, 5'(eCnt[0]), 16'(eAcc[0]), 1'b0}) begin bad++; $display("[TB] FAIL bp_hold got=%h want=%h", snap, {1'b1, 5'(eCnt[0]), 16'(eAcc[0]), 1'b0}); end
                @(posedge clk); #1;
                mOutReady = 1'b1;
            end
            begin
                for (int c = 0; c < 80 && k < 6; c++) begin
                    @(negedge clk);
                    if (mOutValid && mOutReady) begin
                        total++; if (mOutCount !== 5'(eCnt[k])) begin bad++; $display("[TB] FAIL bp_count[%0d] got=%0d want=%0d", k, mOutCount, eCnt[k]); end
                        total++; if (mOutAcc !== 16'(eAcc[k])) begin bad++; $display("[TB] FAIL bp_acc[%0d] got=%0d want=%0d", k, mOutAcc, eAcc[k]); end
                        total++; if (mOutLast !== (k == 5)) begin bad++; $display("[TB] FAIL bp_last[%0d] got=%b want=%b", k, mOutLast, k == 5); end
                        k++;
                    end
                end
                total++; if (k != 6) begin bad++; $display("[TB] FAIL bp_beats got=%0d want=6", k); end
            end
        join
        @(negedge clk);
        total++; if (mOutValid !== 1'b0) begin bad++; $display("[TB] FAIL bp_no_dup got=%b want=0", mOutValid); end
    endtask

    task automatic test_saturation();
        logic [15:0] beats [4];
        logic        lasts [4];
        int          eCnt  [4];
        longint      eAcc  [4];
        bit          eOvf  [4];
        longint      acc = 0;
        bit          ovf = 1'b0;
        int          k = 0;
        beats = '{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0001};
        lasts = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) refBeat({16'h0, beats[i]}, 16, 5, 1'b1, lasts[i], acc, ovf, eCnt[i], eAcc[i], eOvf[i]);
        sOutReady = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(posedge clk); #1;
            if (cyc < 4) begin
                sInValid = 1'b1; sInData = beats[cyc]; sInLast = lasts[cyc]; sAccEn = 1'b1;
            end else begin
                sInValid = 1'b0;
            end
            @(negedge clk);
            if (sOutValid && sOutReady && k < 4) begin
                total++; if (sOutCount !== 5'(eCnt[k])) begin bad++; $display("[TB] FAIL sat_count[%0d] got=%0d want=%0d", k, sOutCount, eCnt[k]); end
                total++; if (sOutAcc !== 5'(eAcc[k])) begin bad++; $display("[TB] FAIL sat_acc[%0d] got=%0d want=%0d", k, sOutAcc, eAcc[k]); end
                total++; if (sOutOvf !== eOvf[k]) begin bad++; $display("[TB] FAIL sat_ovf[%0d] got=%b want=%b", k, sOutOvf, eOvf[k]); end
                total++; if (sOutLast !== lasts[k]) begin bad++; $display("[TB] FAIL sat_last[%0d] got=%b want=%b", k, sOutLast, lasts[k]); end
                k++;
            end
        end
        total++; if (k != 4) begin bad++; $display("[TB] FAIL sat_beats got=%0d want=4", k); end
    endtask

    task automatic test_reset_midpacket();
        @(posedge clk); #1;
        mOutReady = 1'b0; mInValid = 1'b1; mInData = 16'($urandom()); mAccEn = 1'b1; mInLast = 1'b0;
        @(posedge clk); #1;
        mInData = 16'($urandom());
        @(posedge clk); #1;
        mInValid = 1'b0;
        @(negedge clk);
        total++; if (mOutValid !== 1'b1) begin bad++; $display("[TB] FAIL rst_inflight got=%b want=1", mOutValid); end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total++; if (mOutValid !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_valid got=%b want=0", mOutValid); end
        total++; if (mInReady !== 1'b1) begin bad++; $display("[TB] FAIL rst_in_ready got=%b want=1", mInReady); end
        total++; if (mOutAcc !== 16'd0) begin bad++; $display("[TB] FAIL rst_out_acc got=%0d want=0", mOutAcc); end
        @(posedge clk); #1;
        rst = 1'b0; mOutReady = 1'b1; mInValid = 1'b1; mInData = 16'h00FF; mAccEn = 1'b1; mInLast = 1'b1;
        @(posedge clk); #1;
        mInValid = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (mOutValid !== 1'b1) begin bad++; $display("[TB] FAIL rst_new_valid got=%b want=1", mOutValid); end
        total++; if (mOutAcc !== 16'd8) begin bad++; $display("[TB] FAIL rst_new_acc got=%0d want=8", mOutAcc); end
        total++; if (mOutCount !== 5'd8) begin bad++; $display("[TB] FAIL rst_new_count got=%0d want=8", mOutCount); end
    endtask

    task automatic test_sweep();
        beat_t  q4[$], q8[$], q32[$];
        beat_t  b4, b8, b32;
        longint acc4 = 0, acc8 = 0, acc32 = 0;
        bit     ovf4 = 1'b0, ovf8 = 1'b0, ovf32 = 1'b0;
        int     c4, c8, c32;
        longint a4, a8, a32;
        bit     o4, o8, o32;
        bit     done = 1'b0;
        bit     allTook = 1'b0;
        fork
            begin
                for (int c = 0; c < 400; c++) begin
                    @(posedge clk); #1;
                    if (!wInValid || allTook) begin
                        wInValid = ($urandom_range(0, 9) < 7);
                        wInData  = $urandom();
                        wInLast  = ($urandom_range(0, 3) == 0);
                        wAccEn   = ($urandom_range(0, 3) != 0);
                    end
                    wOutReady = ($urandom_range(0, 9) < 7);
                    @(negedge clk);
                    allTook = wInValid && w4InReady && w8InReady && w32InReady;
                end
                for (int c = 0; c < 50 && wInValid && !allTook; c++) begin
                    @(posedge clk); #1;
                    wOutReady = 1'b1;
                    @(negedge clk);
                    allTook = wInValid && w4InReady && w8InReady && w32InReady;
                end
                @(posedge clk); #1;
                wInValid = 1'b0; wOutReady = 1'b1; done = 1'b1;
            end
            begin
                for (int c = 0; c < 3000; c++) begin
                    @(negedge clk);
                    if (wInValid && w4InReady) q4.push_back('{wInData, wInLast, wAccEn});
                    if (w4OutValid && wOutReady) begin
                        total++;
                        if (q4.size() == 0) begin bad++; $display("[TB] FAIL sweep4_extra got=beat want=none"); end
                        else begin
                            b4 = q4.pop_front();
                            refBeat(b4.data, 4, 16, b4.en, b4.last, acc4, ovf4, c4, a4, o4);
                            if ({w4OutCount, w4OutAcc, w4OutLast, w4OutOvf} !== {3'(c4), 16'(a4), b4.last, o4}) begin
                                bad++; $display("[TB] FAIL sweep4_beat got=%0d/%0d/%b/%b want=%0d/%0d/%b/%b", w4OutCount, w4OutAcc, w4OutLast, w4OutOvf, c4, a4, b4.last, o4);
                            end
                        end
                    end
                    if (done && q4.size() == 0) break;
                end
                total++; if (q4.size() != 0) begin bad++; $display("[TB] FAIL sweep4_drain got=%0d want=0", q4.size()); end
            end
            begin
                for (int c = 0; c < 3000; c++) begin
                    @(negedge clk);
                    if (wInValid && w8InReady) q8.push_back('{wInData, wInLast, wAccEn});
                    if (w8OutValid && wOutReady) begin
                        total++;
                        if (q8.size() == 0) begin bad++; $display("[TB] FAIL sweep8_extra got=beat want=none"); end
                        else begin
                            b8 = q8.pop_front();
                            refBeat(b8.data, 8, 16, b8.en, b8.last, acc8, ovf8, c8, a8, o8);
                            if ({w8OutCount, w8OutAcc, w8OutLast, w8OutOvf} !== {4'(c8), 16'(a8), b8.last, o8}) begin
                                bad++; $display("[TB] FAIL sweep8_beat got=%0d/%0d/%b/%b want=%0d/%0d/%b/%b", w8OutCount, w8OutAcc, w8OutLast, w8OutOvf, c8, a8, b8.last, o8);
                            end
                        end
                    end
                    if (done && q8.size() == 0) break;
                end
                total++; if (q8.size() != 0) begin bad++; $display("[TB] FAIL sweep8_drain got=%0d want=0", q8.size()); end
            end
            begin
                for (int c = 0; c < 3000; c++) begin
                    @(negedge clk);
                    if (wInValid && w32InReady) q32.push_back('{wInData, wInLast, wAccEn});
                    if (w32OutValid && wOutReady) begin
                        total++;
                        if (q32.size() == 0) begin bad++; $display("[TB] FAIL sweep32_extra got=beat want=none"); end
                        else begin
                            b32 = q32.pop_front();
                            refBeat(b32.data, 32, 16, b32.en, b32.last, acc32, ovf32, c32, a32, o32);
                            if ({w32OutCount, w32OutAcc, w32OutLast, w32OutOvf} !== {6'(c32), 16'(a32), b32.last, o32}) begin
                                bad++; $display("[TB] FAIL sweep32_beat got=%0d/%0d/%b/%b want=%0d/%0d/%b/%b", w32OutCount, w32OutAcc, w32OutLast, w32OutOvf, c32, a32, b32.last, o32);
                            end
                        end
                    end
                    if (done && q32.size() == 0) break;
                end
                total++; if (q32.size() != 0) begin bad++; $display("[TB] FAIL sweep32_drain got=%0d want=0", q32.size()); end
            end
        join
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        mInValid = 1'b0; mInData = '0; mInLast = 1'b0; mAccEn = 1'b0; mOutReady = 1'b0;
        sInValid = 1'b0; sInData = '0; sInLast = 1'b0; sAccEn = 1'b0; sOutReady = 1'b0;
        wInValid = 1'b0; wInData = '0; wInLast = 1'b0; wAccEn = 1'b0; wOutReady = 1'b0;
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_backpressure();
        test_saturation();
        test_reset_midpacket();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
